// File: rtl/musicbox_pkg.sv
// Shared musicbox definitions: note word layout, octave-0 pitch table and sequencer states.
package musicbox_pkg;

  localparam int PITCH_MSB = 11;
  localparam int PITCH_LSB = 8;
  localparam int OCT_MSB   = 7;
  localparam int OCT_LSB   = 5;
  localparam int DUR_MSB   = 4;
  localparam int DUR_LSB   = 0;

  // Half-periods in 50 MHz cycles for C8..C9; zero entries decode as rests.
  localparam logic [15:0] BASE_HALF [0:15] = '{
    16'd0,    16'd5972, 16'd5637, 16'd5321, 16'd5022, 16'd4740, 16'd4474, 16'd4223,
    16'd3986, 16'd3762, 16'd3551, 16'd3352, 16'd3164, 16'd2986, 16'd0,    16'd0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    NEXT  = 2'd3
  } state_t;

  // Largest result is 0xFFFF << 7, which still fits 24 bits.
  function automatic logic [23:0] half_period(input logic [3:0] pitch, input logic [2:0] oct);
    return {8'd0, BASE_HALF[pitch]} << oct;
  endfunction

endpackage

// File: rtl/score_player_tone_gen.sv
// Square-wave generator: toggles every half_per cycles while enabled, silent otherwise.
module tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] half_per,
  input  logic        en,
  input  logic        clr,
  output logic        speaker
);

  logic [23:0] cnt;
  logic        phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr || !en || half_per == 24'd0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == half_per - 24'd1) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

  // Gating by en silences the pin in the very cycle PLAY is left.
  assign speaker = phase & en;

endmodule

// File: rtl/score_player.sv
// Score sequencer: walks the score memory, times each note in beat ticks and drives the tone generator.
module score_player
  import musicbox_pkg::*;
#(
  parameter int TICK_DIV  = 3_125_000,
  parameter int SCORE_LEN = 150,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] addr,
  input  logic [11:0]       q,
  output logic              speaker,
  output logic              busy,
  output logic              done,
  output logic [3:0]        cur_pitch
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [4:0]      note_cnt;
  logic [23:0]     half_q;

  logic [3:0]  q_pitch;
  logic [2:0]  q_oct;
  logic [4:0]  q_dur;
  logic [23:0] q_half;

  assign q_pitch = q[PITCH_MSB:PITCH_LSB];
  assign q_oct   = q[OCT_MSB:OCT_LSB];
  assign q_dur   = q[DUR_MSB:DUR_LSB];
  assign q_half  = half_period(q_pitch, q_oct);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      tick_cnt  <= '0;
      note_cnt  <= '0;
      half_q    <= '0;
      cur_pitch <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        cur_pitch <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= FETCH;
              addr  <= '0;
            end
          end
          FETCH: begin
            tick_cnt <= '0;
            note_cnt <= q_dur;
            half_q   <= q_half;
            if (q_dur == 5'd0) begin
              state <= NEXT;
            end else begin
              state     <= PLAY;
              // Rest codes (table entry 0) report pitch 0.
              cur_pitch <= (q_half == 24'd0) ? 4'd0 : q_pitch;
            end
          end
          PLAY: begin
            if (tick_cnt == TW'(TICK_DIV - 1)) begin
              tick_cnt <= '0;
              if (note_cnt == 5'd1) begin
                state     <= NEXT;
                cur_pitch <= '0;
              end else begin
                note_cnt <= note_cnt - 5'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          NEXT: begin
            if (addr == ADDR_W'(SCORE_LEN - 1)) begin
              if (loop) begin
                state <= FETCH;
                addr  <= '0;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              state <= FETCH;
              addr  <= addr + ADDR_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  tone_gen u_tone (
    .clk      (clk),
    .rst_n    (rst_n),
    .half_per (half_q),
    .en       (state == PLAY),
    .clr      (state == FETCH),
    .speaker  (speaker)
  );

endmodule
